// File: rtl/dataflow_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit DP_LAT-cycle datapath among NREQ requesters; tags results with requester id.
// Latency: DP_LAT+1 cycles from handshake to rsp_valid; one operand per cycle.
// Backpressure: only req_ready (combinational grant); responses cannot stall. Optional counter: DFSCHED_STATS_EN.
module dataflow_rr_scheduler #(
    parameter int NREQ   = 4,
    parameter int IDW    = $clog2(NREQ),
    parameter int DP_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [7:0]           dp_data_in,
    input  logic [7:0]           dp_data_out,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_data,
    input  logic                 drain_req,
    output logic                 drain_done,
    output logic                 busy,
    output logic [15:0]          grant_cnt
);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_DRAINED = 2'd2} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_gate;
    logic           w_hit;
    logic           w_hs;
    logic [IDW-1:0] w_gidx;
    logic [IDW-1:0] r_ptr;
    logic [DP_LAT-1:0] r_tag_vld;
    logic [IDW-1:0] r_tag_id [DP_LAT];
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [7:0]     r_rsp_data;

    // Find the first valid requester at or after the pointer, wrapping around
    always_comb begin : p_search
        int idx;
        idx    = 0;
        w_hit  = 1'b0;
        w_gidx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_hit && req_valid[IDW'(idx)]) begin
                w_hit  = 1'b1;
                w_gidx = IDW'(idx);
            end
        end
    end

    assign w_hs = w_gate && w_hit;

    // One-hot grant and operand mux; both read zero when nothing is granted
    always_comb begin
        req_ready  = '0;
        dp_data_in = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (w_hs && (w_gidx == IDW'(i))) begin
                req_ready[i] = 1'b1;
                dp_data_in   = req_data[8*i +: 8];
            end
        end
    end

    // Pointer moves past the granted requester only on a handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
        end
    end

    // Tag pipeline mirrors the datapath latency; bubbles travel as valid=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int k = 0; k < DP_LAT; k++) r_tag_id[k] <= '0;
        end else begin
            r_tag_vld[0] <= w_hs;
            r_tag_id[0]  <= w_gidx;
            for (int k = 1; k < DP_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

    // Response register; id and data hold when the tag at the datapath output is a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= 8'h00;
        end else begin
            r_rsp_valid <= r_tag_vld[DP_LAT-1];
            if (r_tag_vld[DP_LAT-1]) begin
                r_rsp_id   <= r_tag_id[DP_LAT-1];
                r_rsp_data <= dp_data_out;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (|r_tag_vld) | r_rsp_valid;

    // Drain FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    // Drain FSM next state; a started drain always completes before returning to RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:     if (drain_req) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (!busy)     w_state_nxt = S_DRAINED;
            S_DRAINED: if (!drain_req) w_state_nxt = S_RUN;
            default:   w_state_nxt = S_RUN;
        endcase
    end

    // Drain FSM outputs; grants stop in the very cycle drain_req rises and during reset
    always_comb begin
        w_gate     = (r_state == S_RUN) && !drain_req && !rst;
        drain_done = (r_state == S_DRAINED);
    end

`ifdef DFSCHED_STATS_EN
    logic [15:0] r_grant_cnt;

    // Saturating count of accepted operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt <= 16'h0000;
        end else if (w_hs && (r_grant_cnt != 16'hFFFF)) begin
            r_grant_cnt <= r_grant_cnt + 16'h0001;
        end
    end

    assign grant_cnt = r_grant_cnt;
`else
    assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dataflow_rr_scheduler.sv
// Bench for dataflow_rr_scheduler: directed steps then random traffic, checked against a queue-based model.
// The datapath stand-in returns operand+1 after DP_LAT cycles.
// Every cycle all outputs are compared with the model at mid-cycle.
module tb_dataflow_rr_scheduler;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int DP_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        dp_data_in;
    logic [7:0]        dp_data_out;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_data;
    logic              drain_req = 1'b0;
    logic              drain_done;
    logic              busy;
    logic [15:0]       grant_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dataflow_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .DP_LAT(DP_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .drain_req(drain_req), .drain_done(drain_done), .busy(busy), .grant_cnt(grant_cnt)
    );

    // Datapath stand-in: result = operand + 1, DP_LAT cycles after capture
    logic [7:0] dp_pipe [DP_LAT];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DP_LAT; k++) dp_pipe[k] <= 8'h00;
        end else begin
            dp_pipe[0] <= dp_data_in + 8'd1;
            for (int k = 1; k < DP_LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
        end
    end
    assign dp_data_out = dp_pipe[DP_LAT-1];

    // Reference model
    typedef struct {
        int         due;
        int         id;
        logic [7:0] dat;
    } rsp_t;
    rsp_t        m_q[$];
    int          m_ptr;
    int          m_mode;      // 0 run, 1 draining, 2 drained
    int          m_cyc;
    int          m_cnt;
    logic [7:0]  m_last_dat;
    logic [IDW-1:0] m_last_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, m_cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr = 0; m_mode = 0; m_cyc = 0; m_cnt = 0;
        m_last_dat = 8'h00; m_last_id = '0;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model across the edge
    task automatic tick();
        int         g;
        int         best;
        int         d;
        logic       due;
        logic       was_busy;
        logic [7:0] op;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        g = -1; best = NREQ; op = 8'h00;
        if (m_mode == 0 && !drain_req) begin
            for (int i = 0; i < NREQ; i++) begin
                d = (i - m_ptr + NREQ) % NREQ;
                if (req_valid[i] && d < best) begin best = d; g = i; end
            end
        end
        exp_rdy = '0;
        if (g >= 0) begin exp_rdy[g] = 1'b1; op = req_data[8*g +: 8]; end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("dp_data_in", 32'(dp_data_in), 32'(op));
        due = (m_q.size() > 0) && (m_q[0].due == m_cyc);
        if (due) begin m_last_id = IDW'(m_q[0].id); m_last_dat = m_q[0].dat; end
        chk("rsp_valid", 32'(rsp_valid), 32'(due));
        chk("rsp_id", 32'(rsp_id), 32'(m_last_id));
        chk("rsp_data", 32'(rsp_data), 32'(m_last_dat));
        was_busy = (m_q.size() > 0);
        chk("busy", 32'(busy), 32'(was_busy));
        chk("drain_done", 32'(drain_done), 32'(m_mode == 2));
`ifdef DFSCHED_STATS_EN
        chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
`else
        chk("grant_cnt", 32'(grant_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        if (due) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back('{due: m_cyc + DP_LAT + 1, id: g, dat: op + 8'd1});
            m_ptr = (g + 1) % NREQ;
            if (m_cnt < 65535) m_cnt++;
        end
        case (m_mode)
            0: if (drain_req) m_mode = 1;
            1: if (!was_busy) m_mode = 2;
            default: if (!drain_req) m_mode = 0;
        endcase
        m_cyc++;
    endtask

    // Assert reset for one edge, checking reset values even with requesters valid
    task automatic do_reset();
        req_valid = '1; drain_req = 1'b0; rst = 1'b1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_dp_data_in", 32'(dp_data_in), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_drain_done", 32'(drain_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_cnt", 32'(grant_cnt), 32'd0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        do_reset();
        repeat (2) tick();

        // Single requester 0 sends 0x05
        req_valid = 4'b0001; req_data = 32'h0000_0005; tick();
        req_valid = 4'b0000; repeat (5) tick();

        // All four valid from ptr 0: grants 0,1,2,3,0
        do_reset();
        req_valid = 4'b1111; req_data = 32'h01FF_1020;
        repeat (5) tick();
        req_valid = 4'b0000; repeat (5) tick();

        // Requesters 1 and 3 with ptr=2; ptr holds across an idle cycle
        req_valid = 4'b0010; req_data = 32'h4433_2211; tick();   // grant 1 -> ptr 2
        req_valid = 4'b1010; repeat (2) tick();                   // grants 3, 1
        req_valid = 4'b0000; tick();                              // idle, ptr stays 2
        req_valid = 4'b1010; tick();                              // grant 3
        req_valid = 4'b0000; repeat (5) tick();

        // Drain after two back-to-back grants, then resume
        req_valid = 4'b0011; req_data = 32'h0000_7766; repeat (2) tick();
        drain_req = 1'b1; repeat (8) tick();
        drain_req = 1'b0; repeat (4) tick();
        req_valid = 4'b0000; repeat (4) tick();

        // Drain with nothing in flight
        drain_req = 1'b1; repeat (4) tick();
        drain_req = 1'b0; repeat (2) tick();

        // Drain request withdrawn mid-drain still completes the drain
        req_valid = 4'b0100; req_data = 32'h00AB_0000; tick();
        drain_req = 1'b1; tick();
        drain_req = 1'b0; repeat (8) tick();

        // Reset one cycle after a handshake discards the in-flight operand
        req_valid = 4'b0001; req_data = 32'h0000_0033; tick();
        do_reset();
        repeat (6) tick();

        // Random traffic with occasional drain toggling
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom);
            req_data  = $urandom;
            if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
            tick();
        end
        drain_req = 1'b0; req_valid = '0;
        repeat (10) tick();

`ifdef DFSCHED_STATS_EN
        // Counter saturation
        do_reset();
        req_valid = 4'b0001; req_data = 32'h0;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("grant_cnt_sat", 32'(grant_cnt), 32'h0000_FFFF);
        @(posedge clk); #1;
        do_reset();
        repeat (2) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
